// File: rtl/lowx_mem_responder.sv
// lowX memory-side responder: line-granular backing array behind an in-order
// request queue, answering each request a fixed number of cycles after acceptance.
package ceres_param;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned BLK_SIZE = 128;
   localparam int unsigned ID_W     = 4;

   typedef struct packed {
      logic                valid;
      logic                ready;
      logic [XLEN-1:0]     addr;
      logic                rw;
      logic [BLK_SIZE-1:0] data;
      logic [ID_W-1:0]     id;
   } lowX_req_t;

   typedef struct packed {
      logic                valid;
      logic                ready;
      logic [BLK_SIZE-1:0] data;
      logic [ID_W-1:0]     id;
   } lowX_res_t;
endpackage

module lowx_mem_responder #(
   parameter int unsigned MEM_LINES = 1024,
   parameter int unsigned BLK_SIZE  = ceres_param::BLK_SIZE,
   parameter int unsigned XLEN      = ceres_param::XLEN,
   parameter int unsigned LATENCY   = 4,
   parameter int unsigned QDEPTH    = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  ceres_param::lowX_req_t mem_req_i,
   output ceres_param::lowX_res_t mem_res_o
);
   localparam int unsigned LW      = $clog2(MEM_LINES);
   localparam int unsigned BOFFSET = $clog2(BLK_SIZE / 8);
   localparam int unsigned PW      = $clog2(QDEPTH);
   localparam int unsigned CW      = PW + 1;
   localparam int unsigned TW      = 4;
   localparam int unsigned IW      = ceres_param::ID_W;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_WAIT  = 2'd1,
      ST_RESP  = 2'd2
   } state_e;

   logic [BLK_SIZE-1:0] mem_r    [MEM_LINES];
   logic [BLK_SIZE-1:0] q_data_r [QDEPTH];
   logic [IW-1:0]       q_id_r   [QDEPTH];
   logic [TW-1:0]       q_tmr_r  [QDEPTH];
   logic [TW-1:0]       tmr_nxt_s[QDEPTH];

   logic [PW-1:0]       rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s;
   logic [CW-1:0]       cnt_r, cnt_nxt_s;
   state_e              state_r;
   logic                valid_r, ready_r;
   logic [BLK_SIZE-1:0] data_r;
   logic [IW-1:0]       id_r;

   logic [XLEN-1:0]     addr_s;
   logic                unused_addr_s;
   logic [LW-1:0]       line_s;
   logic                push_s, pop_s, head_rdy_nxt_s;
   logic [BLK_SIZE-1:0] push_data_s, head_data_nxt_s;
   logic [IW-1:0]       head_id_nxt_s;

   // Queue bookkeeping: accept/pop decisions and the head as it will look after this edge.
   always_comb begin
      addr_s        = mem_req_i.addr;
      unused_addr_s = ^addr_s;
      line_s        = addr_s[BOFFSET +: LW];
      push_s        = mem_req_i.valid && ready_r;
      pop_s         = valid_r && mem_req_i.ready;
      push_data_s   = mem_req_i.rw ? mem_req_i.data : mem_r[line_s];
      rd_ptr_nxt_s  = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
      cnt_nxt_s     = cnt_r + CW'(push_s) - CW'(pop_s);
      for (int i = 0; i < QDEPTH; i++) begin
         if (push_s && (wr_ptr_r == PW'(i))) begin
            tmr_nxt_s[i] = TW'(LATENCY - 1);
         end else if (q_tmr_r[i] != '0) begin
            tmr_nxt_s[i] = q_tmr_r[i] - TW'(1);
         end else begin
            tmr_nxt_s[i] = '0;
         end
      end
      // A push into the slot that becomes head (empty queue, or pop+push at depth 1) wins.
      if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_data_nxt_s = push_data_s;
         head_id_nxt_s   = mem_req_i.id;
      end else begin
         head_data_nxt_s = q_data_r[rd_ptr_nxt_s];
         head_id_nxt_s   = q_id_r[rd_ptr_nxt_s];
      end
      head_rdy_nxt_s = (cnt_nxt_s != '0) && (tmr_nxt_s[rd_ptr_nxt_s] == '0);
   end

   // Backing array: written on an accepted write; reads sample the old contents.
   always_ff @(posedge clk_i) begin
      if (push_s && mem_req_i.rw) begin
         mem_r[line_s] <= mem_req_i.data;
      end
   end

   // Queue entry storage and the parallel latency countdown.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < QDEPTH; i++) begin
            q_data_r[i] <= '0;
            q_id_r[i]   <= '0;
            q_tmr_r[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            q_tmr_r[i] <= tmr_nxt_s[i];
         end
         if (push_s) begin
            q_data_r[wr_ptr_r] <= push_data_s;
            q_id_r[wr_ptr_r]   <= mem_req_i.id;
         end
      end
   end

   // Head FSM with pointers, occupancy and registered response outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r  <= ST_EMPTY;
         valid_r  <= 1'b0;
         ready_r  <= 1'b0;
         data_r   <= '0;
         id_r     <= '0;
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         rd_ptr_r <= rd_ptr_nxt_s;
         wr_ptr_r <= push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
         cnt_r    <= cnt_nxt_s;
         ready_r  <= (cnt_nxt_s != CW'(QDEPTH));
         data_r   <= head_data_nxt_s;
         id_r     <= head_id_nxt_s;
         case (state_r)
            ST_EMPTY: begin
               if (push_s) begin
                  state_r <= head_rdy_nxt_s ? ST_RESP : ST_WAIT;
                  valid_r <= head_rdy_nxt_s;
               end else begin
                  state_r <= ST_EMPTY;
                  valid_r <= 1'b0;
               end
            end
            ST_WAIT: begin
               state_r <= head_rdy_nxt_s ? ST_RESP : ST_WAIT;
               valid_r <= head_rdy_nxt_s;
            end
            ST_RESP: begin
               if (!pop_s) begin
                  state_r <= ST_RESP;
                  valid_r <= 1'b1;
               end else if (cnt_nxt_s == '0) begin
                  state_r <= ST_EMPTY;
                  valid_r <= 1'b0;
               end else begin
                  state_r <= head_rdy_nxt_s ? ST_RESP : ST_WAIT;
                  valid_r <= head_rdy_nxt_s;
               end
            end
            default: begin
               state_r <= ST_EMPTY;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Response port; fields not listed are held at zero.
   always_comb begin
      mem_res_o       = '0;
      mem_res_o.valid = valid_r;
      mem_res_o.ready = ready_r;
      mem_res_o.data  = data_r;
      mem_res_o.id    = id_r;
   end
endmodule

// File: tb/tb_lowx_mem_responder.sv
// Directed bench for lowx_mem_responder: one task per scenario, each with its own checks.
module tb_lowx_mem_responder;
   logic clk;
   logic rst_n;
   ceres_param::lowX_req_t req;
   ceres_param::lowX_res_t res;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0]   cap_id_q[$];
   logic [127:0] cap_data_q[$];

   localparam logic [127:0] D_A5 = {8{16'hA5A5}};
   localparam logic [127:0] D_33 = {16{8'h33}};
   localparam logic [127:0] D_55 = {16{8'h55}};

   lowx_mem_responder #(.MEM_LINES(1024), .LATENCY(4), .QDEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_res_o(res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // record every response handshake, sampled mid-cycle
   always @(negedge clk) begin
      if (rst_n && res.valid && req.ready) begin
         cap_id_q.push_back(res.id);
         cap_data_q.push_back(res.data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // drive a request and hold it until accepted; valid is left high
   task automatic push(input logic rw, input logic [31:0] addr, input logic [127:0] data,
                       input logic [3:0] id);
      bit acc;
      acc = 1'b0;
      req.valid = 1'b1; req.rw = rw; req.addr = addr; req.data = data; req.id = id;
      for (int k = 0; k < 20 && !acc; k++) begin
         acc = res.ready;
         tick();
      end
      n_cmp++;
      if (!acc) begin
         n_err++;
         $display("FAIL push_accept id=%0d: accepted=%0b required=1", id, acc);
      end
   endtask

   task automatic wait_caps(input int n);
      for (int k = 0; k < 40 && cap_id_q.size() < n; k++) tick();
      n_cmp++;
      if (cap_id_q.size() < n) begin
         n_err++;
         $display("FAIL resp_count: got %0d required %0d", cap_id_q.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = '0;
      repeat (3) tick();
      n_cmp++;
      if (res.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b required 0", res.valid); end
      n_cmp++;
      if (res.ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b required 0", res.ready); end
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (res.ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b required 1", res.ready); end
      n_cmp++;
      if (res.valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b required 0", res.valid); end
   endtask

   task automatic test_round_trip();
      req.ready = 1'b1;
      cap_id_q.delete(); cap_data_q.delete();
      push(1'b1, 32'h100, D_A5, 4'd2);
      push(1'b0, 32'h100, 128'h0, 4'd3);
      req.valid = 1'b0;
      n_cmp++;
      if (res.valid !== 1'b0) begin n_err++; $display("FAIL rt_early1 valid: got %b required 0", res.valid); end
      tick();
      n_cmp++;
      if (res.valid !== 1'b0) begin n_err++; $display("FAIL rt_early2 valid: got %b required 0", res.valid); end
      tick();
      n_cmp++;
      if ({res.valid, res.id} !== {1'b1, 4'd2}) begin
         n_err++; $display("FAIL rt_write_ack valid/id: got %b/%0d required 1/2", res.valid, res.id);
      end
      tick();
      n_cmp++;
      if ({res.valid, res.id} !== {1'b1, 4'd3}) begin
         n_err++; $display("FAIL rt_read_latency valid/id: got %b/%0d required 1/3", res.valid, res.id);
      end
      n_cmp++;
      if (res.data !== D_A5) begin n_err++; $display("FAIL rt_read_data: got %h required %h", res.data, D_A5); end
      tick();
      n_cmp++;
      if (res.valid !== 1'b0) begin n_err++; $display("FAIL rt_drain valid: got %b required 0", res.valid); end
   endtask

   task automatic test_queue_full();
      req.ready = 1'b0;
      cap_id_q.delete(); cap_data_q.delete();
      for (int i = 0; i < 4; i++) begin
         push(1'b0, 32'h100, 128'h0, 4'(i));
         n_cmp++;
         if (res.ready !== (i < 3)) begin
            n_err++; $display("FAIL qf_ready after accept %0d: got %b required %b", i, res.ready, (i < 3));
         end
      end
      req.id = 4'd4;
      tick();
      n_cmp++;
      if (res.ready !== 1'b0) begin n_err++; $display("FAIL qf_held ready: got %b required 0", res.ready); end
      n_cmp++;
      if ({res.valid, res.id} !== {1'b1, 4'd0}) begin
         n_err++; $display("FAIL qf_head valid/id: got %b/%0d required 1/0", res.valid, res.id);
      end
      req.ready = 1'b1;
      push(1'b0, 32'h100, 128'h0, 4'd4);
      req.valid = 1'b0;
      wait_caps(5);
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (i >= cap_id_q.size()) begin
            n_err++; $display("FAIL qf_order[%0d]: missing required id %0d", i, i);
         end else if (cap_id_q[i] !== 4'(i)) begin
            n_err++; $display("FAIL qf_order[%0d]: got id %0d required %0d", i, cap_id_q[i], i);
         end
      end
   endtask

   task automatic test_rw_order();
      logic [3:0]   eid [4];
      logic [127:0] edat[4];
      eid  = '{4'd1, 4'd5, 4'd6, 4'd7};
      edat = '{D_33, D_33, D_55, D_55};
      req.ready = 1'b1;
      cap_id_q.delete(); cap_data_q.delete();
      push(1'b1, 32'h70, D_33, 4'd1);
      push(1'b0, 32'h70, 128'h0, 4'd5);
      push(1'b1, 32'h70, D_55, 4'd6);
      push(1'b0, 32'h70, 128'h0, 4'd7);
      req.valid = 1'b0;
      wait_caps(4);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (i >= cap_id_q.size()) begin
            n_err++; $display("FAIL rw_order[%0d]: missing required id %0d", i, eid[i]);
         end else if ({cap_id_q[i], cap_data_q[i]} !== {eid[i], edat[i]}) begin
            n_err++; $display("FAIL rw_order[%0d]: got id %0d data %h required id %0d data %h",
                              i, cap_id_q[i], cap_data_q[i], eid[i], edat[i]);
         end
      end
   endtask

   task automatic test_alias();
      req.ready = 1'b1;
      cap_id_q.delete(); cap_data_q.delete();
      push(1'b1, 32'h0, 128'h1, 4'd8);
      push(1'b0, 32'h4000, 128'h0, 4'd9);
      req.valid = 1'b0;
      wait_caps(2);
      n_cmp++;
      if (cap_id_q.size() < 2) begin
         n_err++; $display("FAIL alias_read: missing response required id 9");
      end else if ({cap_id_q[1], cap_data_q[1]} !== {4'd9, 128'h1}) begin
         n_err++; $display("FAIL alias_read: got id %0d data %h required id 9 data 1", cap_id_q[1], cap_data_q[1]);
      end
   endtask

   task automatic test_backpressure();
      req.ready = 1'b0;
      cap_id_q.delete(); cap_data_q.delete();
      push(1'b0, 32'h0, 128'h0, 4'd10);
      req.valid = 1'b0;
      for (int k = 0; k < 20 && !res.valid; k++) tick();
      n_cmp++;
      if (res.valid !== 1'b1) begin n_err++; $display("FAIL bp_pending valid: got %b required 1", res.valid); end
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         n_cmp++;
         if ({res.valid, res.id, res.data} !== {1'b1, 4'd10, 128'h1}) begin
            n_err++; $display("FAIL bp_stable cycle %0d: got %b/%0d/%h required 1/10/1", j, res.valid, res.id, res.data);
         end
         @(posedge clk);
         #1;
      end
      req.ready = 1'b1;
      tick();
      tick();
      n_cmp++;
      if (res.valid !== 1'b0) begin n_err++; $display("FAIL bp_pop valid: got %b required 0", res.valid); end
      n_cmp++;
      if (cap_id_q.size() != 1) begin
         n_err++; $display("FAIL bp_single_pop: got %0d responses required 1", cap_id_q.size());
      end
   endtask

   task automatic test_reset_midflight();
      req.ready = 1'b0;
      push(1'b0, 32'h0, 128'h0, 4'd11);
      push(1'b0, 32'h0, 128'h0, 4'd12);
      push(1'b0, 32'h0, 128'h0, 4'd13);
      req.valid = 1'b0;
      tick();
      n_cmp++;
      if (res.valid !== 1'b1) begin n_err++; $display("FAIL rm_pending valid: got %b required 1", res.valid); end
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({res.valid, res.ready} !== 2'b00) begin
         n_err++; $display("FAIL rm_async valid/ready: got %b/%b required 0/0", res.valid, res.ready);
      end
      cap_id_q.delete(); cap_data_q.delete();
      req.ready = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick();
      n_cmp++;
      if (res.ready !== 1'b1) begin n_err++; $display("FAIL rm_ready_after: got %b required 1", res.ready); end
      repeat (10) tick();
      n_cmp++;
      if (cap_id_q.size() != 0) begin
         n_err++; $display("FAIL rm_stale: got %0d responses required 0", cap_id_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_round_trip();
      test_queue_full();
      test_rw_order();
      test_alias();
      test_backpressure();
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/lowx_mem_responder.md
# lowx_mem_responder

Memory-side responder for the `lowX` line-transfer protocol. It accepts `lowX_req_t` line requests from an L2 cache or L2 bank arbiter and returns `lowX_res_t` responses after a programmable latency. It is backed by a line-granular storage array and holds up to `QDEPTH` outstanding requests, answered strictly in order. It is the default simulation and FPGA backing store below the L2 and is the reference responder for L2 memory-side verification.

## Interface
- `MEM_LINES`, 1024 — number of cache lines in the backing array; power of two.
- `BLK_SIZE`, `ceres_param::BLK_SIZE` — line size in bits (default 128).
- `XLEN`, `ceres_param::XLEN` — carried through for field widths.
- `LATENCY`, 4 — cycles from request acceptance to earliest response; range 1..15.
- `QDEPTH`, 4 — outstanding-request queue depth; power of two, at least 2.

- `clk_i` input 1 — single clock, rising edge.
- `rst_ni` input 1 — reset, asynchronous, active-low.
- `mem_req_i` input `lowX_req_t` — request from the cache side:
  - `valid`, `addr`, `rw` (1 = write), `data` (full line), `id`.
  - `ready` = the requester can accept a response this cycle.
- `mem_res_o` output `lowX_res_t` — response to the cache side:
  - `valid`, `data`, `id`.
  - `ready` = the responder can accept a request this cycle.
  - All other fields are driven 0.

## Operation
- **Line index:** `addr[BOFFSET +: $clog2(MEM_LINES)]`, where `BOFFSET = $clog2(BLK_SIZE/8)`. Upper address bits are ignored, so addresses alias and wrap modulo `MEM_LINES`. Byte-offset bits are ignored.
- **Accept:** a request is accepted at a clock edge where `mem_req_i.valid && mem_res_o.ready`. `mem_res_o.ready = !queue_full`. There is no bypass: when the queue is full, a same-cycle pop does not free a slot for that cycle's request.
- **Write on accept:** the line is written into the array at the accept edge. The queue entry stores `id` and `data = written data`. The response acts as a write acknowledge.
- **Read on accept:** array data is sampled at the accept edge (read-before-write within the same edge) and stored in the entry. Every read returns the array state as of its acceptance, which preserves program order across the in-order queue.
- **Entry contents:** `{id, data, timer}`. `timer` loads `LATENCY-1` on push, decrements each cycle while nonzero, and saturates at 0. All entries count down in parallel.
- **Head FSM:**
  - `EMPTY`: queue empty, `valid` = 0. On push, go to `WAIT`, or to `RESP` if `LATENCY == 1`.
  - `WAIT`: head timer > 0, `valid` = 0. Go to `RESP` when the head timer reaches 0.
  - `RESP`: `valid` = 1, with `data` and `id` taken from the head entry and held stable. At an edge with `mem_req_i.ready` = 1, pop the head. After the pop, go to `RESP` if the new head timer is 0, to `WAIT` if it is nonzero, or to `EMPTY` if the queue is empty.
- **Simultaneous push and pop** in the same cycle (queue not full) are both performed; occupancy is unchanged.
- **Pointers:** read and write pointers are `$clog2(QDEPTH)` bits and wrap naturally. A `$clog2(QDEPTH)+1`-bit count distinguishes full from empty.

## Timing
- **Reset values:**
  - `mem_res_o.valid` = 0 and `mem_res_o.ready` = 0 while `rst_ni` = 0.
  - `ready` rises in the first cycle after deassertion.
  - Queue empty, FSM in `EMPTY`, pointers and count at 0.
  - The array is not reset; its contents are undefined until written.
- **Reset mid-operation:** all in-flight entries are discarded and `valid` drops asynchronously. No response is produced for requests accepted before the reset.
- **Latency:** a request accepted at edge T drives `valid` = 1 in the cycle after edge T+LATENCY−1, i.e. LATENCY cycles after acceptance, provided it is at the head.
- **Back-to-back requests:** with `mem_req_i.ready` held at 1, requests accepted on consecutive edges respond on consecutive cycles.
- **Throughput:** 1 request per cycle until `QDEPTH` are outstanding.
- **Backpressure:** `valid`, `data` and `id` stay constant while waiting for `mem_req_i.ready`, with no glitching between edges.

## Test plan
- **Single-line round trip:** write line 0x10 (addr 0x100) with data 0xA5A5…, id 2; then read 0x100, id 3. Required: two responses in order, the read's `data` = 0xA5A5…, `id` = 3, and the read's `valid` first asserted exactly LATENCY (4) cycles after its acceptance.
- **Queue full:** issue 5 back-to-back reads with `mem_req_i.ready` = 0. Required: `mem_res_o.ready` drops after the 4th accept and the 5th request is held. Raise `mem_req_i.ready`: after the first pop, the 5th is accepted. Responses arrive in id order 0..4.
- **Read-then-write ordering:** accept a read of line 7 and a write of 0x55… to line 7 on consecutive edges. Required: the read returns the old contents and a later read returns 0x55….
- **Aliasing:** with `MEM_LINES` = 1024 and `BLK_SIZE` = 128, write 0x1 at addr 0x0, then read addr 0x4000. Required: returns 0x1.
- **Backpressure stability:** with a response pending, hold `mem_req_i.ready` = 0 for 6 cycles. Required: `valid`, `data` and `id` stay constant, then a single pop occurs on the first edge with ready = 1.
- **Reset mid-flight:** with 3 requests outstanding, pulse `rst_ni` low asynchronously between edges. Required: `valid` and `ready` go to 0 immediately; after release, no stale responses appear and `ready` = 1 one cycle later.
